// File: rtl/iommu_arb_pkg.sv
// Shared types for the IOMMU hook arbiter: FSM state encoding and address width.
package iommu_arb_pkg;

    localparam int unsigned IOVA_W = 64;
    localparam int unsigned PA_W   = 64;

    typedef logic [IOVA_W-1:0] addr_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } arb_state_e;

endpackage

// File: rtl/iommu_arb_rr_pick.sv
// Combinational round-robin picker: searches req starting one past last, wrapping
// modulo NREQ, and returns the first hit as one-hot, encoded id and any-valid.
module rr_pick #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  id,
    output logic            any
);

    logic [IDW-1:0] idx;

    always_comb begin
        gnt = '0;
        id  = '0;
        any = 1'b0;
        idx = '0;
        for (int unsigned off = 1; off <= NREQ; off++) begin
            idx = IDW'((32'(last) + off) % NREQ);
            if (!any && req[idx]) begin
                any      = 1'b1;
                id       = idx;
                gnt[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/iommu_arb.sv
// Round-robin arbiter/sequencer sharing the single-slot iommu_hook port among NREQ clients.
// Optional response timeout with late-response drain: define IOMMU_ARB_TIMEOUT_EN.
module iommu_arb
    import iommu_arb_pkg::*;
#(
    parameter int unsigned NREQ           = 4,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          cli_req_valid,
    input  logic [NREQ*IOVA_W-1:0]   cli_req_iova,
    output logic [NREQ-1:0]          cli_req_ready,
    output logic [NREQ-1:0]          cli_rsp_valid,
    output logic [PA_W-1:0]          cli_rsp_pa,
    output logic                     cli_rsp_fault,
    input  logic [NREQ-1:0]          cli_rsp_ready,
    output logic                     mmu_req_valid,
    output logic [IOVA_W-1:0]        mmu_req_iova,
    input  logic                     mmu_req_ready,
    input  logic                     mmu_rsp_valid,
    input  logic [PA_W-1:0]          mmu_rsp_pa,
    input  logic                     mmu_rsp_fault,
    output logic                     mmu_rsp_ready,
    output logic                     busy,
    output logic [$clog2(NREQ)-1:0]  grant_id
);

    localparam int unsigned IDW = $clog2(NREQ);

    arb_state_e          state_q, state_d;
    logic [IDW-1:0]      last_q, last_d;
    logic [IDW-1:0]      id_q, id_d;
    addr_t               iova_q, iova_d;
    logic [PA_W-1:0]     pa_q, pa_d;
    logic                fault_q, fault_d;

    logic [NREQ-1:0]     pick_gnt;
    logic [IDW-1:0]      pick_id;
    logic                pick_any;
    logic                arb_en;

`ifdef IOMMU_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                stale_q, stale_d;
`else
    logic                stale_q;
    assign stale_q = 1'b0;
`endif

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req  (cli_req_valid),
        .last (last_q),
        .gnt  (pick_gnt),
        .id   (pick_id),
        .any  (pick_any)
    );

    always_comb begin
        state_d       = state_q;
        last_d        = last_q;
        id_d          = id_q;
        iova_d        = iova_q;
        pa_d          = pa_q;
        fault_d       = fault_q;
        mmu_req_valid = 1'b0;
        mmu_rsp_ready = 1'b0;
        cli_rsp_valid = '0;
`ifdef IOMMU_ARB_TIMEOUT_EN
        cnt_d         = cnt_q;
        stale_d       = stale_q;
`endif
        // rst_n gate keeps the combinational grant low while reset is held
        arb_en        = (state_q == IDLE) && !stale_q && rst_n;
        cli_req_ready = arb_en ? pick_gnt : '0;

        unique case (state_q)
            IDLE: begin
                if (arb_en && pick_any) begin
                    state_d = ISSUE;
                    id_d    = pick_id;
                    last_d  = pick_id;
                    iova_d  = cli_req_iova[32'(pick_id)*IOVA_W +: IOVA_W];
                end
            end
            ISSUE: begin
                mmu_req_valid = 1'b1;
                if (mmu_req_ready) begin
                    state_d = WAIT;
`ifdef IOMMU_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            WAIT: begin
                mmu_rsp_ready = 1'b1;
                if (mmu_rsp_valid) begin
                    state_d = RESP;
                    pa_d    = mmu_rsp_pa;
                    fault_d = mmu_rsp_fault;
                end
`ifdef IOMMU_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = RESP;
                    pa_d    = '0;
                    fault_d = 1'b1;
                    stale_d = 1'b1;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
`endif
            end
            RESP: begin
                cli_rsp_valid[id_q] = 1'b1;
                if (cli_rsp_ready[id_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef IOMMU_ARB_TIMEOUT_EN
        // The late hook response of a timed-out request is swallowed here
        if (stale_q) begin
            mmu_rsp_ready = 1'b1;
            if (mmu_rsp_valid) begin
                stale_d = 1'b0;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= IDW'(NREQ - 1);
            id_q    <= '0;
            iova_q  <= '0;
            pa_q    <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            id_q    <= id_d;
            iova_q  <= iova_d;
            pa_q    <= pa_d;
            fault_q <= fault_d;
        end
    end

`ifdef IOMMU_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            stale_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            stale_q <= stale_d;
        end
    end
`endif

    assign mmu_req_iova  = iova_q;
    assign cli_rsp_pa    = pa_q;
    assign cli_rsp_fault = fault_q;
    assign busy          = (state_q != IDLE);
    assign grant_id      = id_q;

endmodule

// File: tb/tb_iommu_arb.sv
// Directed bench for iommu_arb with a behavioural hook (configurable latency, PA xor, fault).
// The timeout scenario runs only when IOMMU_ARB_TIMEOUT_EN is defined.
module tb_iommu_arb;

    localparam int unsigned NREQ = 4;
`ifdef IOMMU_ARB_TIMEOUT_EN
    localparam int unsigned TO_CYC = 8;
`else
    localparam int unsigned TO_CYC = 256;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   cli_req_valid = '0;
    logic [NREQ*64-1:0] cli_req_iova = '0;
    logic [NREQ-1:0]   cli_req_ready;
    logic [NREQ-1:0]   cli_rsp_valid;
    logic [63:0]       cli_rsp_pa;
    logic              cli_rsp_fault;
    logic [NREQ-1:0]   cli_rsp_ready = '1;
    logic              mmu_req_valid;
    logic [63:0]       mmu_req_iova;
    logic              mmu_req_ready = 1'b1;
    logic              mmu_rsp_valid;
    logic [63:0]       mmu_rsp_pa;
    logic              mmu_rsp_fault;
    logic              mmu_rsp_ready;
    logic              busy;
    logic [1:0]        grant_id;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    // hook model knobs
    int unsigned hook_delay = 0;
    logic [63:0] hook_xor   = '0;
    logic        hook_fault = 1'b0;

    logic        hk_pend;
    logic [63:0] hk_pa;
    logic        hk_fault;
    int unsigned hk_cnt;

    always #5 clk = ~clk;

    iommu_arb #(
        .NREQ           (NREQ),
        .TIMEOUT_CYCLES (TO_CYC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cli_req_valid (cli_req_valid),
        .cli_req_iova  (cli_req_iova),
        .cli_req_ready (cli_req_ready),
        .cli_rsp_valid (cli_rsp_valid),
        .cli_rsp_pa    (cli_rsp_pa),
        .cli_rsp_fault (cli_rsp_fault),
        .cli_rsp_ready (cli_rsp_ready),
        .mmu_req_valid (mmu_req_valid),
        .mmu_req_iova  (mmu_req_iova),
        .mmu_req_ready (mmu_req_ready),
        .mmu_rsp_valid (mmu_rsp_valid),
        .mmu_rsp_pa    (mmu_rsp_pa),
        .mmu_rsp_fault (mmu_rsp_fault),
        .mmu_rsp_ready (mmu_rsp_ready),
        .busy          (busy),
        .grant_id      (grant_id)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hk_pend  <= 1'b0;
            hk_pa    <= '0;
            hk_fault <= 1'b0;
            hk_cnt   <= 0;
        end else if (mmu_req_valid && mmu_req_ready) begin
            hk_pend  <= 1'b1;
            hk_pa    <= mmu_req_iova ^ hook_xor;
            hk_fault <= hook_fault;
            hk_cnt   <= 0;
        end else if (mmu_rsp_valid && mmu_rsp_ready) begin
            hk_pend  <= 1'b0;
        end else if (hk_pend) begin
            hk_cnt   <= hk_cnt + 1;
        end
    end

    assign mmu_rsp_valid = hk_pend && (hk_cnt >= hook_delay);
    assign mmu_rsp_pa    = hk_pend ? hk_pa : '0;
    assign mmu_rsp_fault = hk_pend && hk_fault;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        cli_req_valid = '0;
        cli_rsp_ready = '1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
    endtask

    task automatic set_iova(input int unsigned c, input logic [63:0] v);
        cli_req_iova[c*64 +: 64] = v;
    endtask

    logic [63:0] iova_tab [NREQ];
    logic [3:0]  acc;

    initial begin
        do_reset();
        check_eq("rst_busy",     64'(busy), 64'd0);
        check_eq("rst_grant_id", 64'(grant_id), 64'd0);
        check_eq("rst_req_vld",  64'(mmu_req_valid), 64'd0);
        check_eq("rst_rsp_rdy",  64'(mmu_rsp_ready), 64'd0);
        check_eq("rst_cli_rsp",  64'(cli_rsp_valid), 64'd0);

        // single client 2, zero-wait hook
        set_iova(2, 64'h0000_1234_5678_9ABC);
        cli_req_valid = 4'b0100;
        #1 check_eq("t1_c0_ready", 64'(cli_req_ready), 64'h4);
        tick();
        cli_req_valid = '0;
        #1;
        check_eq("t1_c1_mreq",  64'(mmu_req_valid), 64'd1);
        check_eq("t1_c1_iova",  mmu_req_iova, 64'h0000_1234_5678_9ABC);
        check_eq("t1_c1_gid",   64'(grant_id), 64'd2);
        check_eq("t1_c1_ready", 64'(cli_req_ready), 64'd0);
        tick();
        check_eq("t1_c2_mreq",  64'(mmu_req_valid), 64'd0);
        check_eq("t1_c2_rrdy",  64'(mmu_rsp_ready), 64'd1);
        check_eq("t1_c2_crsp",  64'(cli_rsp_valid), 64'd0);
        tick();
        check_eq("t1_c3_crsp",  64'(cli_rsp_valid), 64'h4);
        check_eq("t1_c3_pa",    cli_rsp_pa, 64'h0000_1234_5678_9ABC);
        check_eq("t1_c3_fault", 64'(cli_rsp_fault), 64'd0);
        tick();
        check_eq("t1_c4_busy",  64'(busy), 64'd0);
        check_eq("t1_c4_crsp",  64'(cli_rsp_valid), 64'd0);

        // all clients valid: order 0,1,2,3,0 every 4 cycles
        do_reset();
        for (int unsigned i = 0; i < NREQ; i++) begin
            iova_tab[i] = 64'h1111_0000_0000_0101 * 64'(i + 1);
            set_iova(i, iova_tab[i]);
        end
        cli_req_valid = 4'b1111;
        #1;
        for (int unsigned k = 0; k < 5; k++) begin
            check_eq($sformatf("t2_g%0d_ready", k), 64'(cli_req_ready), 64'(4'b0001 << (k % 4)));
            tick();
            check_eq($sformatf("t2_g%0d_gid", k), 64'(grant_id), 64'(k % 4));
            check_eq($sformatf("t2_g%0d_noready", k), 64'(cli_req_ready), 64'd0);
            tick();
            tick();
            check_eq($sformatf("t2_g%0d_crsp", k), 64'(cli_rsp_valid), 64'(4'b0001 << (k % 4)));
            check_eq($sformatf("t2_g%0d_pa", k), cli_rsp_pa, iova_tab[k % 4]);
            tick();
        end
        cli_req_valid = '0;

        // hook PA and fault pass through unmodified
        do_reset();
        hook_xor   = 64'hFFFF_0000_0000_0000;
        hook_fault = 1'b1;
        set_iova(0, 64'h0000_0000_DEAD_BEEF);
        cli_req_valid = 4'b0001;
        #1;
        tick();
        cli_req_valid = '0;
        tick();
        tick();
        check_eq("t3_crsp",  64'(cli_rsp_valid), 64'h1);
        check_eq("t3_pa",    cli_rsp_pa, 64'hFFFF_0000_DEAD_BEEF);
        check_eq("t3_fault", 64'(cli_rsp_fault), 64'd1);
        hook_xor   = '0;
        hook_fault = 1'b0;

        // client 1 stalls its response for 10 cycles while client 3 waits
        do_reset();
        set_iova(1, 64'h0000_0000_0001_1000);
        set_iova(3, 64'h0000_0000_0003_3000);
        cli_req_valid = 4'b1010;
        cli_rsp_ready = 4'b1101;
        #1 check_eq("t4_ready1", 64'(cli_req_ready), 64'h2);
        tick();
        cli_req_valid = 4'b1000;
        tick();
        tick();
        for (int unsigned c = 0; c < 10; c++) begin
            check_eq($sformatf("t4_hold%0d_crsp", c), 64'(cli_rsp_valid), 64'h2);
            check_eq($sformatf("t4_hold%0d_pa", c), cli_rsp_pa, 64'h0000_0000_0001_1000);
            check_eq($sformatf("t4_hold%0d_mreq", c), 64'(mmu_req_valid), 64'd0);
            check_eq($sformatf("t4_hold%0d_ready", c), 64'(cli_req_ready), 64'd0);
            tick();
        end
        cli_rsp_ready = '1;
        #1 check_eq("t4_release_crsp", 64'(cli_rsp_valid), 64'h2);
        tick();
        check_eq("t4_ready3", 64'(cli_req_ready), 64'h8);
        cli_req_valid = '0;

`ifdef IOMMU_ARB_TIMEOUT_EN
        // hook stalls 20 cycles, timeout after 8 WAIT cycles, then drain
        do_reset();
        hook_delay = 20;
        set_iova(0, 64'h0000_0000_0000_5000);
        set_iova(1, 64'h0000_0000_0000_6000);
        cli_req_valid = 4'b0001;
        #1 check_eq("t5_ready0", 64'(cli_req_ready), 64'h1);
        tick();
        cli_req_valid = '0;
        tick();
        check_eq("t5_c2_rrdy", 64'(mmu_rsp_ready), 64'd1);
        repeat (7) tick();
        check_eq("t5_c9_crsp", 64'(cli_rsp_valid), 64'd0);
        check_eq("t5_c9_busy", 64'(busy), 64'd1);
        tick();
        check_eq("t5_c10_crsp",  64'(cli_rsp_valid), 64'h1);
        check_eq("t5_c10_fault", 64'(cli_rsp_fault), 64'd1);
        check_eq("t5_c10_pa",    cli_rsp_pa, 64'd0);
        cli_req_valid = 4'b0010;
        tick();
        check_eq("t5_c11_busy", 64'(busy), 64'd0);
        acc = '0;
        for (int unsigned c = 0; c < 11; c++) begin
            acc |= cli_req_ready;
            tick();
        end
        check_eq("t5_blocked",   64'(acc), 64'd0);
        check_eq("t5_drain_vld", 64'(mmu_rsp_valid), 64'd1);
        check_eq("t5_drain_rdy", 64'(mmu_rsp_ready), 64'd1);
        tick();
        check_eq("t5_next_grant", 64'(cli_req_ready), 64'h2);
        cli_req_valid = '0;
        hook_delay = 0;
`endif

        // reset while in WAIT
        do_reset();
        hook_delay = 5;
        set_iova(1, 64'h0000_0000_0000_7777);
        cli_req_valid = 4'b0010;
        #1;
        tick();
        cli_req_valid = '0;
        tick();
        check_eq("t6_wait_busy", 64'(busy), 64'd1);
        set_iova(0, 64'h0000_0000_0000_0A00);
        set_iova(2, 64'h0000_0000_0000_0C00);
        cli_req_valid = 4'b0101;
        rst_n = 1'b0;
        #1;
        check_eq("t6_rst_ready", 64'(cli_req_ready), 64'd0);
        check_eq("t6_rst_crsp",  64'(cli_rsp_valid), 64'd0);
        check_eq("t6_rst_mreq",  64'(mmu_req_valid), 64'd0);
        check_eq("t6_rst_rrdy",  64'(mmu_rsp_ready), 64'd0);
        check_eq("t6_rst_busy",  64'(busy), 64'd0);
        check_eq("t6_rst_gid",   64'(grant_id), 64'd0);
        check_eq("t6_rst_iova",  mmu_req_iova, 64'd0);
        check_eq("t6_rst_pa",    cli_rsp_pa, 64'd0);
        check_eq("t6_rst_fault", 64'(cli_rsp_fault), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        #1 check_eq("t6_first_grant", 64'(cli_req_ready), 64'h1);
        cli_req_valid = '0;
        hook_delay = 0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
